pattern_frame_controller: RTL

//  Frame sequencer in front of the pattern-recognition pipeline (convolution + zebra detector).

---
 rtl/pattern_ctrl_pkg.sv | 35 +++
 rtl/pattern_frame_controller_if.sv | 12 +
 rtl/vote_window.sv | 47 ++++
 rtl/pattern_frame_controller.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pattern_ctrl_pkg.sv
// Shared types, kernel bank and helpers for the pattern frame controller.
package pattern_ctrl_pkg;

    localparam int unsigned KW    = 8;
    localparam int unsigned KTAPS = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_STREAM,
        ST_DRAIN
    } state_t;

    // Element i is tap (row*3 + col); element 0 sits in the LSBs.
    typedef logic [KTAPS-1:0][KW-1:0] kernel_t;

    // 0 Sobel-X, 1 Sobel-Y, 2 Laplacian, 3 identity (written tap 8 first).
    localparam kernel_t KERNEL_BANK [4] = '{
        {8'h01, 8'h00, 8'hFF, 8'h02, 8'h00, 8'hFE, 8'h01, 8'h00, 8'hFF},
        {8'h01, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFE, 8'hFF},
        {8'h00, 8'h01, 8'h00, 8'h01, 8'hFC, 8'h01, 8'h00, 8'h01, 8'h00},
        {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}
    };

    // Number of set bits in an up-to-8-bit vote history.
    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/pattern_frame_controller_if.sv
// Valid/ready pixel stream with start-of-frame marker.
interface pattern_frame_controller_if #(
    parameter int unsigned W = 8
);
    logic         valid;
    logic         ready;
    logic         sof;
    logic [W-1:0] data;

    modport master (output valid, data, sof, input ready);
    modport slave  (input valid, data, sof, output ready);
endinterface

// File: rtl/vote_window.sv
// N-of-M temporal vote over the most recent per-frame detection results.
module vote_window
    import pattern_ctrl_pkg::*;
#(
    parameter int unsigned VOTE_WINDOW = 4,
    parameter int unsigned VOTE_MIN    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       shift,
    input  logic       bit_in,
    output logic [3:0] vote_count,
    output logic       crossing_stable
);

    logic [VOTE_WINDOW-1:0] history;
    logic [3:0]             ones_c;

    assign ones_c = popcount(8'(history));

    // History shift register, newest result in bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            history <= '0;
        end else if (clear) begin
            history <= '0;
        end else if (shift) begin
            history <= {history[VOTE_WINDOW-2:0], bit_in};
        end
    end

    // Vote outputs trail the history by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_count      <= '0;
            crossing_stable <= 1'b0;
        end else if (clear) begin
            vote_count      <= '0;
            crossing_stable <= 1'b0;
        end else begin
            vote_count      <= ones_c;
            crossing_stable <= (ones_c >= 4'(VOTE_MIN));
        end
    end

endmodule

// File: rtl/pattern_frame_controller.sv
// Frame sequencer: SOF alignment, one-frame forwarding, kernel hold, result wait and vote.
module pattern_frame_controller
    import pattern_ctrl_pkg::*;
#(
    parameter int unsigned IMG_WIDTH      = 320,
    parameter int unsigned IMG_HEIGHT     = 240,
    parameter int unsigned W              = 8,
    parameter int unsigned VOTE_WINDOW    = 4,
    parameter int unsigned VOTE_MIN       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [1:0]                kernel_sel,
    pattern_frame_controller_if.slave  cam,
    pattern_frame_controller_if.master pr_x,
    output logic [KTAPS-1:0][W-1:0]   kernel,
    input  logic                      det_valid,
    input  logic                      det_crossing,
    output logic                      crossing_stable,
    output logic [3:0]                vote_count,
    output logic [15:0]               frame_count,
    output logic                      timeout_err,
    output logic                      busy
);

    localparam int unsigned FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned PIX_W     = $clog2(FRAME_PIX + 1);
    localparam int unsigned WDOG_W    = $clog2(TIMEOUT_CYCLES);

    // Bank entry sign-extended to the output coefficient width.
    function automatic logic [KTAPS-1:0][W-1:0] bank_entry(input logic [1:0] sel);
        logic [KTAPS-1:0][W-1:0] k;
        for (int i = 0; i < KTAPS; i++) begin
            k[i] = W'(signed'(KERNEL_BANK[sel][i]));
        end
        return k;
    endfunction

    state_t                  state, state_d;
    logic [PIX_W-1:0]        pixel_cnt, pixel_cnt_d;
    logic [WDOG_W-1:0]       wdog, wdog_d;
    logic [KTAPS-1:0][W-1:0] kernel_d;
    logic [15:0]             frame_count_d;
    logic                    timeout_d;
    logic                    cam_ready_c;
    logic                    pr_valid_c;
    logic                    pr_sof_c;
    logic                    vote_clear_c;
    logic                    vote_shift_c;
    logic                    vote_bit_c;
    logic                    handshake_c;

    assign handshake_c = cam.valid && pr_x.ready;
    assign cam.ready   = cam_ready_c;
    assign pr_x.valid  = pr_valid_c;
    assign pr_x.sof    = pr_sof_c;
    assign pr_x.data   = cam.data;
    assign busy        = (state != ST_IDLE);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pixel_cnt   <= '0;
            wdog        <= '0;
            kernel      <= bank_entry(2'd0);
            frame_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            pixel_cnt   <= pixel_cnt_d;
            wdog        <= wdog_d;
            kernel      <= kernel_d;
            frame_count <= frame_count_d;
            timeout_err <= timeout_d;
        end
    end

    // Next-state, stream steering and result capture.
    always_comb begin
        state_d       = state;
        pixel_cnt_d   = pixel_cnt;
        wdog_d        = wdog;
        kernel_d      = kernel;
        frame_count_d = frame_count;
        timeout_d     = 1'b0;
        cam_ready_c   = 1'b0;
        pr_valid_c    = 1'b0;
        pr_sof_c      = 1'b0;
        vote_clear_c  = 1'b0;
        vote_shift_c  = 1'b0;
        vote_bit_c    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (enable) begin
                    vote_clear_c = 1'b1;
                    state_d      = ST_WAIT_SOF;
                end
            end

            ST_WAIT_SOF: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (cam.valid && cam.sof) begin
                    // First pixel is forwarded; the kernel locks only on its handshake.
                    pr_valid_c  = 1'b1;
                    pr_sof_c    = 1'b1;
                    cam_ready_c = pr_x.ready;
                    if (pr_x.ready) begin
                        kernel_d    = bank_entry(kernel_sel);
                        pixel_cnt_d = PIX_W'(1);
                        state_d     = ST_STREAM;
                    end
                end else begin
                    // Mid-frame junk before alignment is swallowed.
                    cam_ready_c = 1'b1;
                end
            end

            ST_STREAM: begin
                pr_valid_c  = cam.valid;
                cam_ready_c = pr_x.ready;
                if (handshake_c) begin
                    pixel_cnt_d = pixel_cnt + PIX_W'(1);
                    if (pixel_cnt == PIX_W'(FRAME_PIX - 1)) begin
                        wdog_d  = '0;
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (det_valid) begin
                    vote_shift_c  = 1'b1;
                    vote_bit_c    = det_crossing;
                    frame_count_d = frame_count + 16'd1;
                    state_d       = enable ? ST_WAIT_SOF : ST_IDLE;
                end else if (wdog == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                    // Lost result counts as a negative frame.
                    vote_shift_c  = 1'b1;
                    timeout_d     = 1'b1;
                    frame_count_d = frame_count + 16'd1;
                    state_d       = enable ? ST_WAIT_SOF : ST_IDLE;
                end else begin
                    wdog_d = wdog + WDOG_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    vote_window #(
        .VOTE_WINDOW (VOTE_WINDOW),
        .VOTE_MIN    (VOTE_MIN)
    ) u_vote (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (vote_clear_c),
        .shift           (vote_shift_c),
        .bit_in          (vote_bit_c),
        .vote_count      (vote_count),
        .crossing_stable (crossing_stable)
    );

endmodule
